// File: rtl/id_inst_queue.sv
// IF->ID instruction queue: circular buffer of {pc, inst} with branch flush.
// Define ID_QUEUE_BYPASS_EN for a zero-latency path when the queue is empty.
module id_inst_queue #(
  parameter int DEPTH  = 4,
  parameter int PC_W   = 32,
  parameter int INST_W = 32,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [PC_W-1:0]   in_pc,
  input  logic [INST_W-1:0] in_inst,
  output logic              in_ready,
  output logic              out_valid,
  output logic [PC_W-1:0]   out_pc,
  output logic [INST_W-1:0] out_inst,
  input  logic              out_ready,
  input  logic              flush,
  input  logic              flush_keep,
  output logic [CNT_W-1:0]  count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [PC_W-1:0]   pc_mem   [DEPTH];
  logic [INST_W-1:0] inst_mem [DEPTH];

  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_n;
  logic [CNT_W-1:0] cnt_n;
  logic             empty;
  logic             full;
  logic             pop;
  logic             push;
  logic             wr_en;
  logic             byp;
  logic             byp_take;

  assign empty    = (count == '0);
  assign full     = (count == CNT_W'(DEPTH));
  assign in_ready = ~full | out_ready;
  assign pop      = ~empty & out_ready;
  assign push     = in_valid & in_ready;

`ifdef ID_QUEUE_BYPASS_EN
  assign byp = empty & in_valid & ~flush;
`else
  assign byp = 1'b0;
`endif
  assign byp_take = byp & out_ready;

  always_comb begin
    out_valid = ~empty | byp;
    out_pc    = '0;
    out_inst  = '0;
    if (byp) begin
      out_pc   = in_pc;
      out_inst = in_inst;
    end else if (!empty) begin
      out_pc   = pc_mem[rd_ptr];
      out_inst = inst_mem[rd_ptr];
    end
  end

  always_comb begin
    wr_en = 1'b0;
    cnt_n = count;
    rd_n  = rd_ptr + PTR_W'(pop);
    if (flush) begin
      cnt_n = (~pop & ~empty) ? CNT_W'(1) : '0;
      // delay slot: keep the queued one, else take this cycle's push
      if (flush_keep) begin
        if (count > CNT_W'(1)) begin
          cnt_n = cnt_n + CNT_W'(1);
        end else if (push) begin
          wr_en = 1'b1;
          cnt_n = cnt_n + CNT_W'(1);
        end
      end
    end else begin
      wr_en = push & ~byp_take;
      cnt_n = count + CNT_W'(wr_en) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      rd_ptr <= rd_n;
      wr_ptr <= rd_n + cnt_n[PTR_W-1:0];
      count  <= cnt_n;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      pc_mem[wr_ptr]   <= in_pc;
      inst_mem[wr_ptr] <= in_inst;
    end
  end

endmodule

// File: tb/tb_id_inst_queue.sv
// Self-checking bench for id_inst_queue against a queue-based model.
module tb_id_inst_queue;

  localparam int DEPTH = 4;
  localparam int CNT_W = 3;
`ifdef ID_QUEUE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic [31:0]      in_pc;
  logic [31:0]      in_inst;
  logic             in_ready;
  logic             out_valid;
  logic [31:0]      out_pc;
  logic [31:0]      out_inst;
  logic             out_ready;
  logic             flush;
  logic             flush_keep;
  logic [CNT_W-1:0] count;

  int checks = 0;
  int failures = 0;

  logic [31:0] mpc[$];
  logic [31:0] minst[$];

  id_inst_queue #(.DEPTH(DEPTH), .PC_W(32), .INST_W(32)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_pc(in_pc), .in_inst(in_inst),
    .in_ready(in_ready),
    .out_valid(out_valid), .out_pc(out_pc), .out_inst(out_inst),
    .out_ready(out_ready),
    .flush(flush), .flush_keep(flush_keep),
    .count(count)
  );

  always #5 clk = ~clk;

  // advance one clock edge and apply the same edge to the model
  task automatic tick();
    int n;
    bit pm, rdy, pu, kh, ks;
    logic [31:0] hp, hi, sp, si;
    n   = mpc.size();
    pm  = (n > 0) && out_ready;
    rdy = (n < DEPTH) || out_ready;
    pu  = in_valid && rdy;
    if (flush) begin
      hp = 0; hi = 0; sp = in_pc; si = in_inst;
      if (n > 0) begin hp = mpc[0]; hi = minst[0]; end
      if (n > 1) begin sp = mpc[1]; si = minst[1]; end
      kh = (n > 0) && !pm;
      ks = flush_keep && ((n >= 2) || pu);
      mpc.delete();
      minst.delete();
      if (kh) begin mpc.push_back(hp); minst.push_back(hi); end
      if (ks) begin mpc.push_back(sp); minst.push_back(si); end
    end else if (!(BYP && n == 0 && in_valid && out_ready)) begin
      if (pm) begin void'(mpc.pop_front()); void'(minst.pop_front()); end
      if (pu) begin mpc.push_back(in_pc); minst.push_back(in_inst); end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    in_valid = 0; out_ready = 0; flush = 0; flush_keep = 0;
  endtask

  task automatic load3();
    out_ready = 0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1;
      in_pc = 32'h100 + 32'(4 * i);
      in_inst = $urandom();
      tick();
    end
    idle_inputs();
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if (count !== 0) begin
      failures++; $display("FAIL reset_count got %0d want 0", count);
    end
    checks++;
    if (out_valid !== 0 || in_ready !== 1) begin
      failures++;
      $display("FAIL reset_flags got v=%b r=%b want v=0 r=1", out_valid, in_ready);
    end
    checks++;
    if (out_pc !== 0 || out_inst !== 0) begin
      failures++;
      $display("FAIL reset_out got %h/%h want 0/0", out_pc, out_inst);
    end
  endtask

  task automatic test_fill();
    idle_inputs();
    for (int i = 0; i < 4; i++) begin
      in_valid = 1;
      in_pc = 32'hBFC0_0000 + 32'(4 * i);
      in_inst = $urandom();
      tick();
    end
    in_valid = 0;
    #1;
    checks++;
    if (count !== 4 || in_ready !== 0) begin
      failures++;
      $display("FAIL fill got cnt=%0d rdy=%b want cnt=4 rdy=0", count, in_ready);
    end
    checks++;
    if (out_pc !== 32'hBFC0_0000 || out_valid !== 1) begin
      failures++;
      $display("FAIL fill_head got %h want bfc00000", out_pc);
    end
  endtask

  task automatic test_full_pop();
    out_ready = 1; in_valid = 1;
    in_pc = 32'hBFC0_0010; in_inst = $urandom();
    #1;
    checks++;
    if (in_ready !== 1) begin
      failures++; $display("FAIL full_pop_ready got %b want 1", in_ready);
    end
    tick();
    idle_inputs();
    #1;
    checks++;
    if (count !== 4 || out_pc !== 32'hBFC0_0004) begin
      failures++;
      $display("FAIL full_pop got cnt=%0d pc=%h want 4/bfc00004", count, out_pc);
    end
  endtask

  task automatic test_mid_reset();
    out_ready = 1;
    tick();
    out_ready = 0;
    #1;
    checks++;
    if (count !== 3) begin
      failures++; $display("FAIL mid_pre got %0d want 3", count);
    end
    rst = 0;
    #1;
    checks++;
    if (count !== 0 || out_valid !== 0 || in_ready !== 1 || out_pc !== 0) begin
      failures++;
      $display("FAIL mid_reset got cnt=%0d v=%b r=%b pc=%h want 0/0/1/0",
               count, out_valid, in_ready, out_pc);
    end
    mpc.delete();
    minst.delete();
    @(negedge clk);
    rst = 1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_flush_keep();
    load3();
    flush = 1; flush_keep = 1; out_ready = 1;
    in_valid = 1; in_pc = 32'h10C; in_inst = $urandom();
    tick();
    idle_inputs();
    #1;
    checks++;
    if (count !== 1 || out_pc !== 32'h104) begin
      failures++;
      $display("FAIL flush_keep got cnt=%0d pc=%h want 1/104", count, out_pc);
    end
    out_ready = 1;
    tick();
    idle_inputs();
  endtask

  task automatic test_flush_nokeep();
    load3();
    flush = 1; flush_keep = 0; out_ready = 0;
    in_valid = 1; in_pc = 32'h10C; in_inst = $urandom();
    tick();
    idle_inputs();
    #1;
    checks++;
    if (count !== 1 || out_pc !== 32'h100) begin
      failures++;
      $display("FAIL flush_nokeep got cnt=%0d pc=%h want 1/100", count, out_pc);
    end
    out_ready = 1;
    tick();
    idle_inputs();
  endtask

  task automatic test_bypass();
    in_valid = 1; out_ready = 1;
    in_pc = 32'h200; in_inst = 32'h2400_0001;
    #1;
    checks++;
    if (BYP) begin
      if (out_valid !== 1 || out_pc !== 32'h200 || count !== 0) begin
        failures++;
        $display("FAIL bypass_now got v=%b pc=%h cnt=%0d want 1/200/0",
                 out_valid, out_pc, count);
      end
    end else if (out_valid !== 0) begin
      failures++; $display("FAIL nobypass_now got v=%b want 0", out_valid);
    end
    tick();
    in_valid = 0;
    #1;
    checks++;
    if (BYP) begin
      if (out_valid !== 0 || count !== 0) begin
        failures++;
        $display("FAIL bypass_after got v=%b cnt=%0d want 0/0", out_valid, count);
      end
    end else if (out_valid !== 1 || count !== 1 || out_pc !== 32'h200) begin
      failures++;
      $display("FAIL nobypass_after got v=%b cnt=%0d pc=%h want 1/1/200",
               out_valid, count, out_pc);
    end
    tick();
    #1;
    checks++;
    if (count !== 0 || out_valid !== 0) begin
      failures++;
      $display("FAIL bypass_drain got cnt=%0d v=%b want 0/0", count, out_valid);
    end
    idle_inputs();
  endtask

  task automatic test_random();
    int n;
    bit ev, er;
    logic [31:0] epc, einst;
    for (int c = 0; c < 400; c++) begin
      in_valid   = ($urandom_range(9) < 7);
      out_ready  = ($urandom_range(9) < 5);
      flush      = ($urandom_range(99) < 8);
      flush_keep = $urandom_range(1);
      in_pc      = $urandom() & 32'hFFFF_FFFC;
      in_inst    = $urandom();
      #1;
      n = mpc.size();
      ev = (n > 0);
      epc = 0; einst = 0;
      if (n > 0) begin epc = mpc[0]; einst = minst[0]; end
      if (BYP && n == 0 && in_valid && !flush) begin
        ev = 1; epc = in_pc; einst = in_inst;
      end
      er = (n < DEPTH) || out_ready;
      checks++;
      if (count !== CNT_W'(n)) begin
        failures++; $display("FAIL rnd_count c=%0d got %0d want %0d", c, count, n);
      end
      checks++;
      if (out_valid !== ev || in_ready !== er) begin
        failures++;
        $display("FAIL rnd_flags c=%0d got v=%b r=%b want v=%b r=%b",
                 c, out_valid, in_ready, ev, er);
      end
      checks++;
      if (out_pc !== epc || out_inst !== einst) begin
        failures++;
        $display("FAIL rnd_head c=%0d got %h/%h want %h/%h",
                 c, out_pc, out_inst, epc, einst);
      end
      tick();
    end
    idle_inputs();
  endtask

  initial begin
    rst = 0;
    in_pc = 0;
    in_inst = 0;
    idle_inputs();
    #2;
    test_reset();
    @(negedge clk);
    rst = 1;
    @(posedge clk);
    #1;
    test_fill();
    test_full_pop();
    test_mid_reset();
    test_flush_keep();
    test_flush_nokeep();
    test_bypass();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
